// File: rtl/ysyx_22041071_mem_arb_pkg.sv
// ysyx_22041071_mem_arb_pkg: shared RAM arbiter types, address defaults and range check
package ysyx_22041071_mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} arb_state_e;

    localparam logic [63:0] BASE_ADDR_DEF = 64'h8000_0000;
    localparam int DEPTH_LOG2_DEF = 24;
    localparam int IDX_W = 64;

    // Subtraction underflow for addr < base is caught by the explicit compare, never aliased
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base, input int depth_log2);
        return addr >= base && ((addr - base) >> 3) < (64'd1 << depth_log2);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] addr, input logic [63:0] base);
        return (addr - base) >> 3;
    endfunction

endpackage

// File: rtl/ysyx_22041071_mem_arb_pick.sv
// ysyx_22041071_mem_arb_pick: data-priority grant with bounded fetch starvation
module ysyx_22041071_mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic d_valid,
    input  logic idle,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [3:0] MAX = STARVE_MAX[3:0];

    logic [3:0] starve_cnt;

    assign grant_i = idle && i_valid && (!d_valid || starve_cnt == MAX);
    assign grant_d = idle && d_valid && !grant_i;

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (idle && (grant_i || !i_valid))
            starve_cnt <= '0;
        else if (grant_d && i_valid && starve_cnt != MAX)
            starve_cnt <= starve_cnt + 4'd1;
    end

endmodule

// File: rtl/ysyx_22041071_mem_arb.sv
// ysyx_22041071_mem_arb: sequences fetch and data requests onto the single-ported RAMHelper
module ysyx_22041071_mem_arb
    import ysyx_22041071_mem_arb_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [63:0] i_req_addr,
    output logic        i_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] i_resp_data,
    output logic        i_resp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [63:0] d_req_addr,
    input  logic        d_req_wen,
    input  logic [63:0] d_req_wdata,
    input  logic [63:0] d_req_wmask,
    output logic        d_resp_valid,
    input  logic        d_resp_ready,
    output logic [63:0] d_resp_data,
    output logic        d_resp_err,
    output logic        mem_en,
    output logic [IDX_W-1:0] mem_ridx,
    output logic [IDX_W-1:0] mem_widx,
    input  logic [63:0] mem_rdata,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [63:0] mem_wmask
);

    arb_state_e state;
    logic idle, grant_i, grant_d, ok, rd;
    logic [63:0] addr;
    logic [IDX_W-1:0] idx;

    // Gating idle with reset keeps readies and RAM strobes low during reset
    assign idle = state == IDLE && !reset;

    ysyx_22041071_mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .idle    (idle),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign addr = grant_d ? d_req_addr : i_req_addr;
    assign ok = (grant_i || grant_d) && in_range(addr, BASE_ADDR, DEPTH_LOG2);
    assign idx = ok ? word_idx(addr, BASE_ADDR) : '0;
    assign rd = ok && (grant_i || !d_req_wen);
    assign mem_en = rd;
    assign mem_wen = ok && grant_d && d_req_wen;
    assign mem_ridx = idx;
    assign mem_widx = idx;
    assign mem_wdata = d_req_wdata;
    assign mem_wmask = d_req_wmask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            i_resp_err   <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
            d_resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= RESP_I;
                        i_resp_valid <= 1'b1;
                        i_resp_data  <= ok ? mem_rdata : '0;
                        i_resp_err   <= !ok;
                    end else if (grant_d) begin
                        state        <= RESP_D;
                        d_resp_valid <= 1'b1;
                        d_resp_data  <= rd ? mem_rdata : '0;
                        d_resp_err   <= !ok;
                    end
                end
                RESP_I: begin
                    if (i_resp_ready) begin
                        state        <= IDLE;
                        i_resp_valid <= 1'b0;
                    end
                end
                RESP_D: begin
                    if (d_resp_ready) begin
                        state        <= IDLE;
                        d_resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
